bjack_autoplayer: RTL and testbench

Automatic player for the blackjack game core. It drives the core's active-low START and NEW_CARD inputs the way a person at the buttons would, watches HAND/HOLD/BUST, and plays repeated games against a fixed draw threshold. It keeps saturating tallies of games, holds and busts, and sits beside the game top as an unattended stimulus and soak driver.

---
 rtl/bjack_pkg.sv | 28 ++
 rtl/sat_cnt8.sv | 23 ++
 rtl/bjack_autoplayer.sv | 174 +++++++++++++++++
 tb/tb_bjack_autoplayer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bjack_pkg.sv
// Shared definitions for the blackjack game core and its automatic player:
// FSM encoding, datapath widths and the common draw threshold.
package bjack_pkg;

    localparam int HAND_W        = 5;
    localparam int CNT_W         = 8;
    localparam int DEF_THRESHOLD = 17;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START_P = 3'd1,
        ST_START_W = 3'd2,
        ST_EVAL    = 3'd3,
        ST_CARD_P  = 3'd4,
        ST_CARD_W  = 3'd5,
        ST_GAP     = 3'd6
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sat_cnt8.sv
// Enabled up-counter that sticks at all-ones instead of wrapping.
module sat_cnt8
    import bjack_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/bjack_autoplayer.sv
// Unattended player for the blackjack core: presses START / NEW_CARD like a
// person would, draws below a fixed threshold and tallies game outcomes.
module bjack_autoplayer
    import bjack_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int SETTLE    = 8,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int GAP_LEN   = 16,
    parameter int TIMEOUT   = 255,
    parameter int NUM_GAMES = 0
) (
    input  logic              i_sys_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [HAND_W-1:0] i_hand,
    input  logic              i_hold,
    input  logic              i_bust,
    output logic              o_start_n,
    output logic              o_new_card_n,
    output logic              o_playing,
    output logic [CNT_W-1:0]  o_games,
    output logic [CNT_W-1:0]  o_wins,
    output logic [CNT_W-1:0]  o_busts,
    output logic              o_err,
    output state_t            o_dbg_state
);

    localparam int MAX_WAIT = max4(PULSE_LEN, SETTLE, GAP_LEN, TIMEOUT);
    localparam int TMR_W    = $clog2(MAX_WAIT + 1);
    localparam logic [HAND_W-1:0] THR   = HAND_W'(THRESHOLD);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(NUM_GAMES);

    state_t            r_state, w_next;
    logic [TMR_W-1:0]  r_tmr, w_tmr_nxt, w_tmr_dec;
    logic [HAND_W-1:0] r_hand_q;
    logic              r_hold_d, r_bust_d;
    logic              r_start_n, r_new_card_n, r_playing, r_err;
    logic              w_tmr_zero, w_limit, w_card_ack;
    logic              w_inc_games, w_inc_wins, w_inc_busts;
    logic              w_set_err, w_set_play, w_clr_play, w_latch;
    logic [CNT_W-1:0]  w_games, w_wins, w_busts;

    assign w_tmr_zero = (r_tmr == '0);
    assign w_tmr_dec  = r_tmr - 1'b1;
    assign w_limit    = (NUM_GAMES != 0) && (w_games == LIMIT);
    // A card is acknowledged by a hand change or a fresh HOLD/BUST edge.
    assign w_card_ack = (i_hand != r_hand_q) || (i_hold && !r_hold_d) || (i_bust && !r_bust_d);

    always_comb begin
        w_next      = r_state;
        w_tmr_nxt   = r_tmr;
        w_inc_games = 1'b0;
        w_inc_wins  = 1'b0;
        w_inc_busts = 1'b0;
        w_set_err   = 1'b0;
        w_set_play  = 1'b0;
        w_clr_play  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && !w_limit) begin
                    w_next    = ST_START_P;
                    w_tmr_nxt = TMR_W'(PULSE_LEN - 1);
                end
            end
            ST_START_P: begin
                if (w_tmr_zero) begin
                    w_next    = ST_START_W;
                    w_tmr_nxt = TMR_W'(SETTLE - 1);
                end else begin
                    w_tmr_nxt = w_tmr_dec;
                end
            end
            ST_START_W: begin
                if (!w_tmr_zero) begin
                    w_tmr_nxt = w_tmr_dec;
                end else if ((i_hand == '0) && !i_hold && !i_bust) begin
                    w_next     = ST_EVAL;
                    w_set_play = 1'b1;
                end else begin
                    w_next    = ST_GAP;
                    w_tmr_nxt = TMR_W'(GAP_LEN - 1);
                    w_set_err = 1'b1;
                end
            end
            ST_EVAL: begin
                if (i_bust) begin
                    w_inc_busts = 1'b1;
                    w_inc_games = 1'b1;
                    w_clr_play  = 1'b1;
                    w_next      = ST_GAP;
                    w_tmr_nxt   = TMR_W'(GAP_LEN - 1);
                end else if (i_hold) begin
                    w_inc_wins  = 1'b1;
                    w_inc_games = 1'b1;
                    w_clr_play  = 1'b1;
                    w_next      = ST_GAP;
                    w_tmr_nxt   = TMR_W'(GAP_LEN - 1);
                end else if (i_hand < THR) begin
                    w_latch   = 1'b1;
                    w_next    = ST_CARD_P;
                    w_tmr_nxt = TMR_W'(PULSE_LEN - 1);
                end
            end
            ST_CARD_P: begin
                if (w_tmr_zero) begin
                    w_next    = ST_CARD_W;
                    w_tmr_nxt = TMR_W'(TIMEOUT - 1);
                end else begin
                    w_tmr_nxt = w_tmr_dec;
                end
            end
            ST_CARD_W: begin
                if (w_card_ack) begin
                    w_next = ST_EVAL;
                end else if (w_tmr_zero) begin
                    w_next    = ST_EVAL;
                    w_set_err = 1'b1;
                end else begin
                    w_tmr_nxt = w_tmr_dec;
                end
            end
            ST_GAP: begin
                if (w_tmr_zero) begin
                    w_next = ST_IDLE;
                end else begin
                    w_tmr_nxt = w_tmr_dec;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Buttons are registered from the next state so each pulse spans exactly its state.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_tmr        <= '0;
            r_hand_q     <= '0;
            r_hold_d     <= 1'b0;
            r_bust_d     <= 1'b0;
            r_start_n    <= 1'b1;
            r_new_card_n <= 1'b1;
            r_playing    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_tmr        <= w_tmr_nxt;
            r_hold_d     <= i_hold;
            r_bust_d     <= i_bust;
            r_start_n    <= (w_next != ST_START_P);
            r_new_card_n <= (w_next != ST_CARD_P);
            if (w_latch) r_hand_q <= i_hand;
            if (w_set_play) r_playing <= 1'b1;
            else if (w_clr_play) r_playing <= 1'b0;
            if (w_set_err) r_err <= 1'b1;
        end
    end

    sat_cnt8 u_games (.i_clk(i_sys_clk), .i_rst(i_reset), .i_inc(w_inc_games), .o_cnt(w_games));
    sat_cnt8 u_wins  (.i_clk(i_sys_clk), .i_rst(i_reset), .i_inc(w_inc_wins),  .o_cnt(w_wins));
    sat_cnt8 u_busts (.i_clk(i_sys_clk), .i_rst(i_reset), .i_inc(w_inc_busts), .o_cnt(w_busts));

    assign o_start_n    = r_start_n;
    assign o_new_card_n = r_new_card_n;
    assign o_playing    = r_playing;
    assign o_games      = w_games;
    assign o_wins       = w_wins;
    assign o_busts      = w_busts;
    assign o_err        = r_err;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bjack_autoplayer.sv
// Bench for bjack_autoplayer: a behavioural game core answers the button
// presses, and a scoreboard holds the tallies expected after each game.
module tb_bjack_autoplayer;
    import bjack_pkg::*;

    localparam int PULSE_LEN = 4;
    localparam int EXP_W     = 30;
    localparam int NV        = 7;

    typedef struct {
        int c[4];
        bit bad;
        int n_cards;
        bit win;
        bit bst;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, en_b;
    logic [4:0] hand, hand_b;
    logic       hold, bust, hold_b, bust_b;
    logic       start_n, nc, playing, err;
    logic [7:0] games, wins, busts;
    state_t     st;
    logic       start_n_b, nc_b, playing_b, err_b;
    logic [7:0] games_b, wins_b, busts_b;
    state_t     st_b;

    bjack_autoplayer u_dut (
        .i_sys_clk(clk), .i_reset(rst), .i_enable(en),
        .i_hand(hand), .i_hold(hold), .i_bust(bust),
        .o_start_n(start_n), .o_new_card_n(nc), .o_playing(playing),
        .o_games(games), .o_wins(wins), .o_busts(busts), .o_err(err),
        .o_dbg_state(st)
    );

    bjack_autoplayer #(.NUM_GAMES(3)) u_dut_lim (
        .i_sys_clk(clk), .i_reset(rst), .i_enable(en_b),
        .i_hand(hand_b), .i_hold(hold_b), .i_bust(bust_b),
        .o_start_n(start_n_b), .o_new_card_n(nc_b), .o_playing(playing_b),
        .o_games(games_b), .o_wins(wins_b), .o_busts(busts_b), .o_err(err_b),
        .o_dbg_state(st_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x < 255) ? x + 1 : 255;
    endfunction

    // ---------------- game core model (DUT A) ----------------
    int  h_a = 0;
    bit  bad_mode = 0;
    bit  no_ack = 0;
    int  soak_card = 20;
    int  deck_q[$];
    logic prev_nc = 1'b1;

    task automatic core_a_step();
        int card;
        if (rst || !start_n) begin
            h_a  = bad_mode ? 12 : 0;
            hold = 1'b0;
            bust = 1'b0;
        end else if (prev_nc && !nc && !no_ack) begin
            if (deck_q.size() > 0) card = deck_q.pop_front();
            else card = soak_card;
            h_a = h_a + card;
            if (h_a > 31) h_a = 31;
            bust = (h_a > 21);
            hold = !bust && (h_a >= 17);
        end
        hand = 5'(h_a);
        prev_nc = nc;
    endtask

    initial begin
        hand = '0; hold = 1'b0; bust = 1'b0;
        forever begin
            @(negedge clk);
            core_a_step();
        end
    end

    // ---------------- game core model (DUT B): every card gives 20 ----------------
    logic prev_nc_b = 1'b1;
    logic prev_s_b  = 1'b1;
    int   starts_b  = 0;
    initial begin
        hand_b = '0; hold_b = 1'b0; bust_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !start_n_b) begin
                hand_b = '0; hold_b = 1'b0;
            end else if (prev_nc_b && !nc_b) begin
                hand_b = 5'd20; hold_b = 1'b1;
            end
            if (rst) starts_b = 0;
            else if (prev_s_b && !start_n_b) starts_b++;
            prev_nc_b = nc_b;
            prev_s_b  = start_n_b;
        end
    end

    // ---------------- pulse monitor (DUT A) ----------------
    int s_len = 0, c_len = 0;
    int both_low = 0;
    int card_pulses = 0;
    bit saw_play = 0;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            s_len = 0; c_len = 0;
        end else begin
            if (!start_n && !nc) both_low = 1;
            if (playing) saw_play = 1;
            if (!start_n) s_len++;
            else if (s_len != 0) begin
                check("start_width", s_len, PULSE_LEN);
                check("one_button_low", both_low, 0);
                s_len = 0;
            end
            if (!nc) c_len++;
            else if (c_len != 0) begin
                check("card_width", c_len, PULSE_LEN);
                card_pulses++;
                c_len = 0;
            end
        end
    end

    task automatic wait_state(input state_t s, input int budget, input string what);
        int n = 0;
        while (st != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (st != s) begin
            errors++;
            $display("FAIL wait_%s: state %0d, expected %0d after %0d cycles", what, st, s, budget);
        end
    endtask

    task automatic wait_nc(input logic v, input int budget, input string what);
        int n = 0;
        while (nc !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(what, int'(nc), int'(v));
    endtask

    function automatic vec_t mk_vec(input int c0, input int c1, input int c2, input int c3,
                                    input bit bad, input int n, input bit win, input bit bst);
        vec_t v;
        v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
        v.bad = bad; v.n_cards = n; v.win = win; v.bst = bst;
        return v;
    endfunction

    function automatic logic [EXP_W-1:0] pack(input int g, input int w, input int b,
                                               input int n, input bit pl, input bit er);
        return {er, pl, 4'(n), 8'(b), 8'(w), 8'(g)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] e;
    vec_t vecs[NV];
    int   g_m, w_m, b_m;
    bit   err_m, is_bust;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk_vec(10, 8, 0, 0, 0, 2, 1, 0);
        vecs[1] = mk_vec(10, 5, 9, 0, 0, 3, 0, 1);
        vecs[2] = mk_vec( 9, 9, 0, 0, 0, 2, 1, 0);
        vecs[3] = mk_vec( 5, 5, 5, 5, 0, 4, 1, 0);
        vecs[4] = mk_vec( 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[5] = mk_vec(11,10, 0, 0, 0, 2, 1, 0);
        vecs[6] = mk_vec(16,10, 0, 0, 0, 2, 0, 1);

        rst = 1'b1; en = 1'b0; en_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start_n", int'(start_n), 1);
        check("rst_new_card_n", int'(nc), 1);
        check("rst_playing", int'(playing), 0);
        check("rst_games", int'(games), 0);
        check("rst_wins", int'(wins), 0);
        check("rst_busts", int'(busts), 0);
        check("rst_err", int'(err), 0);
        check("rst_state", int'(st), int'(ST_IDLE));
        rst = 1'b0;

        // Table-driven games; ENABLE drops mid-game each time.
        g_m = 0; w_m = 0; b_m = 0; err_m = 0;
        for (int i = 0; i < NV; i++) begin
            deck_q.delete();
            for (int j = 0; j < 4; j++) if (vecs[i].c[j] != 0) deck_q.push_back(vecs[i].c[j]);
            bad_mode = vecs[i].bad;
            if (vecs[i].bad) err_m = 1;
            else begin
                g_m = sat(g_m);
                if (vecs[i].win) w_m = sat(w_m);
                if (vecs[i].bst) b_m = sat(b_m);
            end
            exp_q.push_back(pack(g_m, w_m, b_m, vecs[i].n_cards, !vecs[i].bad, err_m));
            card_pulses = 0; saw_play = 0;
            en = 1'b1;
            wait_state(ST_START_P, 10, "start");
            en = 1'b0;
            wait_state(ST_GAP, 600, "gap");
            wait_state(ST_IDLE, 40, "idle");
            e = exp_q.pop_front();
            check("vec_games", int'(games), int'(e[7:0]));
            check("vec_wins", int'(wins), int'(e[15:8]));
            check("vec_busts", int'(busts), int'(e[23:16]));
            check("vec_cards", card_pulses, int'(e[27:24]));
            check("vec_saw_playing", int'(saw_play), int'(e[28]));
            check("vec_err", int'(err), int'(e[29]));
            check("vec_playing_low", int'(playing), 0);
        end
        repeat (5) @(negedge clk);
        check("idle_when_disabled", int'(st), int'(ST_IDLE));

        // Card acknowledge timeout.
        bad_mode = 0; deck_q.delete();
        rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
        no_ack = 1; card_pulses = 0; soak_card = 20;
        en = 1'b1;
        wait_state(ST_START_P, 10, "to_start");
        en = 1'b0;
        wait_nc(1'b0, 100, "to_pulse_low");
        wait_nc(1'b1, 10, "to_pulse_high");
        repeat (254) @(negedge clk);
        check("to_err_before", int'(err), 0);
        @(negedge clk);
        check("to_err_after", int'(err), 1);
        check("to_back_in_eval", int'(st), int'(ST_EVAL));
        no_ack = 0;
        wait_state(ST_GAP, 100, "to_gap");
        wait_state(ST_IDLE, 40, "to_idle");
        check("to_cards", card_pulses, 2);
        check("to_games", int'(games), 1);
        check("to_wins", int'(wins), 1);

        // Reset while NEW_CARD_N is low.
        en = 1'b1;
        wait_state(ST_START_P, 10, "rp_start");
        en = 1'b0;
        wait_nc(1'b0, 100, "rp_pulse_low");
        rst = 1'b1;
        @(negedge clk);
        check("rp_new_card_n", int'(nc), 1);
        check("rp_start_n", int'(start_n), 1);
        check("rp_games", int'(games), 0);
        check("rp_wins", int'(wins), 0);
        check("rp_busts", int'(busts), 0);
        check("rp_err", int'(err), 0);
        check("rp_state", int'(st), int'(ST_IDLE));
        rst = 1'b0;

        // Soak past GAMES saturation with random outcomes.
        g_m = 0; w_m = 0; b_m = 0;
        for (int g = 0; g < 257; g++) begin
            soak_card = ($urandom_range(0, 3) == 0) ? 25 : 20;
            is_bust = (soak_card > 21);
            g_m = sat(g_m);
            if (is_bust) b_m = sat(b_m);
            else w_m = sat(w_m);
            exp_q.push_back(pack(g_m, w_m, b_m, 1, 1, 0));
            en = 1'b1;
            wait_state(ST_GAP, 300, "soak_gap");
            wait_state(ST_IDLE, 40, "soak_idle");
            if (g == 256) en = 1'b0;
            e = exp_q.pop_front();
            check("soak_games", int'(games), int'(e[7:0]));
            check("soak_wins", int'(wins), int'(e[15:8]));
            check("soak_busts", int'(busts), int'(e[23:16]));
        end
        check("soak_tally_sum", int'(wins) + int'(busts), 257);
        repeat (20) @(negedge clk);
        check("soak_games_held", int'(games), 255);
        check("soak_idle", int'(st), int'(ST_IDLE));

        // Game limit on the NUM_GAMES=3 instance.
        en_b = 1'b1;
        for (int n = 0; n < 3000 && games_b != 8'd3; n++) @(negedge clk);
        check("lim_games_reached", int'(games_b), 3);
        repeat (1000) @(negedge clk);
        check("lim_starts", starts_b, 3);
        check("lim_games_held", int'(games_b), 3);
        check("lim_wins", int'(wins_b), 3);
        check("lim_state_idle", int'(st_b), int'(ST_IDLE));
        check("lim_start_n_high", int'(start_n_b), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
